// File: rtl/lfb_pkg.sv
// Shared types and helpers for the line fill buffer.
// Latency: n/a (types, constants and a combinational merge function only).
// Backpressure: n/a.
package lfb_pkg;

  localparam int LFB_WORDS = 16;

  // Widest word the merge helper handles; callers zero-extend into it and
  // size-cast the result back down to their own word width.
  localparam int LFB_MAX_W = 128;
  localparam int LFB_MAX_B = LFB_MAX_W / 8;

  typedef logic [3:0] word_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    HOLD
  } lfb_state_t;

  // Per-byte select: a set mask bit takes the new byte, a clear bit keeps the old one.
  function automatic logic [LFB_MAX_W-1:0] byte_merge(
    input logic [LFB_MAX_W-1:0] old_word,
    input logic [LFB_MAX_W-1:0] new_word,
    input logic [LFB_MAX_B-1:0] mask
  );
    logic [LFB_MAX_W-1:0] res;
    res = old_word;
    for (int i = 0; i < LFB_MAX_B; i++) begin
      if (mask[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/lfb_word_merge.sv
// Byte-masked merge of one word onto another, used on the beat write path.
// Latency: purely combinational.
// Backpressure: none; always produces a result.
module lfb_word_merge
  import lfb_pkg::*;
#(
  parameter int width = 16
) (
  input  logic [width-1:0]   old_word,
  input  logic [width-1:0]   new_word,
  input  logic [width/8-1:0] mask,
  output logic [width-1:0]   merged
);

  assign merged = width'(byte_merge(LFB_MAX_W'(old_word), LFB_MAX_W'(new_word), LFB_MAX_B'(mask)));

endmodule

// File: rtl/line_fill_buffer.sv
// Assembles a 16-word cache line from a wrapped memory burst, merging one CPU store.
// Latency: line_valid one edge after the 16th accepted beat (17 cycles from start, no stalls).
// Backpressure: beat_ready only in FILL; merge_ready drops when a second unfilled-word store meets a full pending slot.
// Optional LFB_EARLY_WORD_EN adds early_valid/early_data for the critical word.
module line_fill_buffer
  import lfb_pkg::*;
#(
  parameter int width = 16,
  parameter int WORDS = LFB_WORDS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [3:0]               start_word,
  input  logic                     beat_valid,
  input  logic [width-1:0]         beat_data,
  output logic                     beat_ready,
  input  logic                     merge_en,
  input  logic [3:0]               merge_sel,
  input  logic [width-1:0]         merge_data,
  input  logic [width/8-1:0]       merge_mask,
  output logic                     merge_ready,
  output logic [WORDS*width-1:0]   line_out,
  output logic                     line_valid,
  input  logic                     line_ack,
  output logic                     busy
`ifdef LFB_EARLY_WORD_EN
  ,
  output logic                     early_valid,
  output logic [width-1:0]         early_data
`endif
);

  lfb_state_t state_q, state_d;

  word_idx_t              base_q;
  word_idx_t              count_q;
  word_idx_t              beat_idx;
  logic [LFB_WORDS-1:0]   filled_q;
  logic [width-1:0]       line_q [LFB_WORDS];

  logic                   pend_vld_q;
  word_idx_t              pend_sel_q;
  logic [width-1:0]       pend_data_q;
  logic [width/8-1:0]     pend_mask_q;

  logic                   beat_fire;
  logic                   pend_hit;
  logic                   merge_direct;
  logic                   merge_with_beat;
  logic                   merge_pend;
  logic [width-1:0]       beat_stage;
  logic [width-1:0]       beat_word;
  logic [width-1:0]       direct_word;
  logic [width/8-1:0]     live_mask;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and state-decoded handshake outputs.
  always_comb begin
    state_d    = state_q;
    beat_ready = 1'b0;
    line_valid = 1'b0;
    busy       = (state_q != IDLE);
    case (state_q)
      IDLE: if (start) state_d = FILL;
      FILL: begin
        beat_ready = 1'b1;
        if (beat_valid && count_q == 4'd15) state_d = HOLD;
      end
      HOLD: begin
        line_valid = 1'b1;
        if (line_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign beat_fire = beat_valid && beat_ready;
  // Critical-word-first: 4-bit add wraps the index around the line.
  assign beat_idx  = base_q + count_q;
  assign pend_hit  = pend_vld_q && (pend_sel_q == beat_idx);

  // Classify an incoming store: straight into a filled word, folded into the
  // beat landing on the same word this cycle, parked in the pending slot, or refused.
  always_comb begin
    merge_direct    = 1'b0;
    merge_with_beat = 1'b0;
    merge_pend      = 1'b0;
    if (merge_en && state_q != IDLE) begin
      if (filled_q[merge_sel])                         merge_direct    = 1'b1;
      else if (beat_fire && beat_idx == merge_sel)     merge_with_beat = 1'b1;
      else if (!pend_vld_q)                            merge_pend      = 1'b1;
    end
  end

  assign merge_ready = merge_direct | merge_with_beat | merge_pend;

  // The older pending store is applied before the live one, so the live store wins per byte.
  assign beat_stage = pend_hit
                    ? width'(byte_merge(LFB_MAX_W'(beat_data), LFB_MAX_W'(pend_data_q), LFB_MAX_B'(pend_mask_q)))
                    : beat_data;
  assign live_mask  = merge_with_beat ? merge_mask : '0;

  lfb_word_merge #(.width(width)) u_beat_merge (
    .old_word (beat_stage),
    .new_word (merge_data),
    .mask     (live_mask),
    .merged   (beat_word)
  );

  assign direct_word = width'(byte_merge(LFB_MAX_W'(line_q[merge_sel]), LFB_MAX_W'(merge_data),
                                         LFB_MAX_B'(merge_mask)));

  // Line storage: a beat and a direct store never hit the same word (one is filled, one is not).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LFB_WORDS; k++) line_q[k] <= '0;
    end else begin
      if (beat_fire)    line_q[beat_idx]  <= beat_word;
      if (merge_direct) line_q[merge_sel] <= direct_word;
    end
  end

  // Fill bookkeeping: base, beat count, filled map and the pending store slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q      <= '0;
      count_q     <= '0;
      filled_q    <= '0;
      pend_vld_q  <= 1'b0;
      pend_sel_q  <= '0;
      pend_data_q <= '0;
      pend_mask_q <= '0;
    end else begin
      if (state_q == IDLE && start) begin
        base_q   <= start_word;
        count_q  <= '0;
        filled_q <= '0;
      end
      if (beat_fire) begin
        count_q            <= count_q + 4'd1;
        filled_q[beat_idx] <= 1'b1;
        if (pend_hit) pend_vld_q <= 1'b0;
      end
      if (merge_pend) begin
        pend_vld_q  <= 1'b1;
        pend_sel_q  <= merge_sel;
        pend_data_q <= merge_data;
        pend_mask_q <= merge_mask;
      end
    end
  end

  for (genvar k = 0; k < LFB_WORDS; k++) begin : g_line_out
    assign line_out[k*width +: width] = line_q[k];
  end

`ifdef LFB_EARLY_WORD_EN
  // One-cycle notice of the critical word as written (merges included); data held until the next fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      early_valid <= 1'b0;
      early_data  <= '0;
    end else begin
      early_valid <= beat_fire && (count_q == 4'd0);
      if (beat_fire && count_q == 4'd0) early_data <= beat_word;
    end
  end
`endif

endmodule

// File: tb/tb_line_fill_buffer.sv
// Directed testbench for line_fill_buffer.
// Latency: n/a.
// Backpressure: n/a.
module tb_line_fill_buffer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [3:0]   start_word;
  logic         beat_valid;
  logic [15:0]  beat_data;
  logic         beat_ready;
  logic         merge_en;
  logic [3:0]   merge_sel;
  logic [15:0]  merge_data;
  logic [1:0]   merge_mask;
  logic         merge_ready;
  logic [255:0] line_out;
  logic         line_valid;
  logic         line_ack;
  logic         busy;
`ifdef LFB_EARLY_WORD_EN
  logic         early_valid;
  logic [15:0]  early_data;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0]  exp_line [16];
  logic [255:0] exp_vec;

  line_fill_buffer #(.width(16), .WORDS(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .start_word  (start_word),
    .beat_valid  (beat_valid),
    .beat_data   (beat_data),
    .beat_ready  (beat_ready),
    .merge_en    (merge_en),
    .merge_sel   (merge_sel),
    .merge_data  (merge_data),
    .merge_mask  (merge_mask),
    .merge_ready (merge_ready),
    .line_out    (line_out),
    .line_valid  (line_valid),
    .line_ack    (line_ack),
    .busy        (busy)
`ifdef LFB_EARLY_WORD_EN
    ,
    .early_valid (early_valid),
    .early_data  (early_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start      = 1'b0;
    start_word = 4'd0;
    beat_valid = 1'b0;
    beat_data  = 16'h0000;
    merge_en   = 1'b0;
    merge_sel  = 4'd0;
    merge_data = 16'h0000;
    merge_mask = 2'b00;
    line_ack   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    merge_en = 1'b1;
    #12;
    n_checks++; if (line_out !== 256'd0) begin n_fail++; $display("FAIL reset_line_out got %h want 0", line_out); end
    n_checks++; if (line_valid !== 1'b0) begin n_fail++; $display("FAIL reset_line_valid got %b want 0", line_valid); end
    n_checks++; if (beat_ready !== 1'b0) begin n_fail++; $display("FAIL reset_beat_ready got %b want 0", beat_ready); end
    n_checks++; if (merge_ready !== 1'b0) begin n_fail++; $display("FAIL reset_merge_ready got %b want 0", merge_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
`ifdef LFB_EARLY_WORD_EN
    n_checks++; if (early_valid !== 1'b0 || early_data !== 16'h0) begin n_fail++; $display("FAIL reset_early got %b/%h want 0/0000", early_valid, early_data); end
`endif
    merge_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_linear();
    start = 1'b1; start_word = 4'd0;
    tick();
    start = 1'b0;
    n_checks++; if (busy !== 1'b1 || beat_ready !== 1'b1) begin n_fail++; $display("FAIL lin_fill_entry got busy=%b ready=%b want 1/1", busy, beat_ready); end
    for (int k = 0; k < 16; k++) begin
      beat_valid = 1'b1;
      beat_data  = 16'(16'h1000 + k);
      exp_line[k] = 16'(16'h1000 + k);
      tick();
      if (k == 14) begin
        n_checks++; if (line_valid !== 1'b0) begin n_fail++; $display("FAIL lin_early_valid got %b want 0 after 15 beats", line_valid); end
      end
    end
    beat_valid = 1'b0;
    n_checks++; if (line_valid !== 1'b1) begin n_fail++; $display("FAIL lin_line_valid got %b want 1", line_valid); end
    n_checks++; if (beat_ready !== 1'b0) begin n_fail++; $display("FAIL lin_beat_ready got %b want 0", beat_ready); end
    for (int k = 0; k < 16; k++) begin
      n_checks++; if (line_out[k*16 +: 16] !== exp_line[k]) begin n_fail++; $display("FAIL lin_word%0d got %h want %h", k, line_out[k*16 +: 16], exp_line[k]); end
    end
    line_ack = 1'b1;
    tick();
    line_ack = 1'b0;
    n_checks++; if (busy !== 1'b0 || line_valid !== 1'b0) begin n_fail++; $display("FAIL lin_ack got busy=%b valid=%b want 0/0", busy, line_valid); end
  endtask

  task automatic test_wrap();
    start = 1'b1; start_word = 4'd13;
    tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      beat_valid = 1'b1;
      beat_data  = 16'(16'hC000 + i * 16'h0101);
      exp_line[4'(13 + i)] = 16'(16'hC000 + i * 16'h0101);
      tick();
    end
    beat_valid = 1'b0;
    n_checks++; if (line_out[13*16 +: 16] !== 16'hC000) begin n_fail++; $display("FAIL wrap_word13 got %h want c000", line_out[13*16 +: 16]); end
    n_checks++; if (line_out[12*16 +: 16] !== 16'hCF0F) begin n_fail++; $display("FAIL wrap_word12 got %h want cf0f", line_out[12*16 +: 16]); end
    for (int k = 0; k < 16; k++) begin
      n_checks++; if (line_out[k*16 +: 16] !== exp_line[k]) begin n_fail++; $display("FAIL wrap_word%0d got %h want %h", k, line_out[k*16 +: 16], exp_line[k]); end
    end
    line_ack = 1'b1;
    tick();
    line_ack = 1'b0;
  endtask

  task automatic test_merge();
    start = 1'b1; start_word = 4'd0;
    tick();
    start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      beat_valid = 1'b1;
      beat_data  = (k == 5) ? 16'h1234 : 16'(16'h1000 + k);
      merge_en   = 1'b0;
      case (k)
        0: begin merge_en = 1'b1; merge_sel = 4'd5; merge_mask = 2'b01; merge_data = 16'h00AB; end
        1: begin merge_en = 1'b1; merge_sel = 4'd9; merge_mask = 2'b11; merge_data = 16'hFFFF; end
        2: begin merge_en = 1'b1; merge_sel = 4'd0; merge_mask = 2'b10; merge_data = 16'hCD00; end
        7: begin merge_en = 1'b1; merge_sel = 4'd7; merge_mask = 2'b10; merge_data = 16'h7700; end
        default: ;
      endcase
      #1;
      if (k == 0) begin n_checks++; if (merge_ready !== 1'b1) begin n_fail++; $display("FAIL merge_pend_take got %b want 1", merge_ready); end end
      if (k == 1) begin n_checks++; if (merge_ready !== 1'b0) begin n_fail++; $display("FAIL merge_pend_full got %b want 0", merge_ready); end end
      if (k == 2) begin n_checks++; if (merge_ready !== 1'b1) begin n_fail++; $display("FAIL merge_direct got %b want 1", merge_ready); end end
      if (k == 7) begin n_checks++; if (merge_ready !== 1'b1) begin n_fail++; $display("FAIL merge_same_cycle got %b want 1", merge_ready); end end
      tick();
    end
    beat_valid = 1'b0;
    merge_en = 1'b1; merge_sel = 4'd2; merge_mask = 2'b11; merge_data = 16'h1111;
    #1;
    n_checks++; if (merge_ready !== 1'b1) begin n_fail++; $display("FAIL merge_hold1 got %b want 1", merge_ready); end
    tick();
    merge_sel = 4'd2; merge_mask = 2'b01; merge_data = 16'h0022;
    tick();
    merge_sel = 4'd3; merge_mask = 2'b00; merge_data = 16'hFFFF;
    #1;
    n_checks++; if (merge_ready !== 1'b1) begin n_fail++; $display("FAIL merge_zero_mask got %b want 1", merge_ready); end
    tick();
    merge_en = 1'b0;
    for (int k = 0; k < 16; k++) exp_line[k] = 16'(16'h1000 + k);
    exp_line[0] = 16'hCD00;
    exp_line[2] = 16'h1122;
    exp_line[5] = 16'h12AB;
    exp_line[7] = 16'h7707;
    for (int k = 0; k < 16; k++) begin
      n_checks++; if (line_out[k*16 +: 16] !== exp_line[k]) begin n_fail++; $display("FAIL merge_word%0d got %h want %h", k, line_out[k*16 +: 16], exp_line[k]); end
    end
    line_ack = 1'b1;
    tick();
    line_ack = 1'b0;
    merge_en = 1'b1; merge_sel = 4'd1; merge_mask = 2'b11;
    #1;
    n_checks++; if (merge_ready !== 1'b0) begin n_fail++; $display("FAIL merge_idle got %b want 0", merge_ready); end
    merge_en = 1'b0;
  endtask

  task automatic test_stall_hold();
    start = 1'b1; start_word = 4'd4;
    tick();
    start = 1'b0;
    for (int j = 0; j < 16; j++) exp_line[4'(4 + j)] = 16'(16'h2000 + j);
    for (int k = 0; k < 16; k++) exp_vec[k*16 +: 16] = exp_line[k];
    for (int i = 0; i < 32; i++) begin
      if (i % 2 == 0) begin beat_valid = 1'b1; beat_data = 16'(16'h2000 + i / 2); end
      else            begin beat_valid = 1'b0; beat_data = 16'hDEAD; end
      tick();
      if (i == 29) begin
        n_checks++; if (line_valid !== 1'b0) begin n_fail++; $display("FAIL stall_valid_early got %b want 0", line_valid); end
      end
    end
    for (int h = 0; h < 3; h++) begin
      start = 1'b1; start_word = 4'd0; beat_valid = 1'b1; beat_data = 16'hFFFF;
      #1;
      n_checks++; if (line_valid !== 1'b1 || beat_ready !== 1'b0) begin n_fail++; $display("FAIL stall_hold%0d got valid=%b ready=%b want 1/0", h, line_valid, beat_ready); end
      n_checks++; if (line_out !== exp_vec) begin n_fail++; $display("FAIL stall_line%0d got %h want %h", h, line_out, exp_vec); end
      tick();
    end
    start = 1'b0; beat_valid = 1'b0; line_ack = 1'b1;
    tick();
    line_ack = 1'b0;
    n_checks++; if (busy !== 1'b0 || line_valid !== 1'b0) begin n_fail++; $display("FAIL stall_ack got busy=%b valid=%b want 0/0", busy, line_valid); end
    tick();
    n_checks++; if (busy !== 1'b0 || line_out !== exp_vec) begin n_fail++; $display("FAIL stall_idle got busy=%b line=%h want 0/%h", busy, line_out, exp_vec); end
  endtask

  task automatic test_reset_mid();
    start = 1'b1; start_word = 4'd0;
    tick();
    start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      beat_valid = 1'b1; beat_data = 16'(16'h3000 + k);
      tick();
    end
    beat_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    merge_en = 1'b1; merge_sel = 4'd2; merge_mask = 2'b11;
    #1;
    n_checks++; if (line_out !== 256'd0) begin n_fail++; $display("FAIL rmid_line_out got %h want 0", line_out); end
    n_checks++; if (busy !== 1'b0 || beat_ready !== 1'b0 || line_valid !== 1'b0 || merge_ready !== 1'b0) begin
      n_fail++; $display("FAIL rmid_ctrl got busy=%b br=%b lv=%b mr=%b want 0000", busy, beat_ready, line_valid, merge_ready); end
`ifdef LFB_EARLY_WORD_EN
    n_checks++; if (early_valid !== 1'b0 || early_data !== 16'h0) begin n_fail++; $display("FAIL rmid_early got %b/%h want 0/0000", early_valid, early_data); end
`endif
    merge_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    start = 1'b1; start_word = 4'd2;
    tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      beat_valid = 1'b1;
      beat_data  = 16'(16'h4000 + i);
      exp_line[4'(2 + i)] = 16'(16'h4000 + i);
      merge_en   = (i == 0);
      merge_sel  = 4'd5; merge_mask = 2'b11; merge_data = 16'h5555;
      #1;
      if (i == 0) begin n_checks++; if (merge_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_merge got %b want 1", merge_ready); end end
      tick();
    end
    beat_valid = 1'b0; merge_en = 1'b0;
    exp_line[5] = 16'h5555;
    n_checks++; if (line_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_refill_valid got %b want 1", line_valid); end
    for (int k = 0; k < 16; k++) begin
      n_checks++; if (line_out[k*16 +: 16] !== exp_line[k]) begin n_fail++; $display("FAIL rmid_word%0d got %h want %h", k, line_out[k*16 +: 16], exp_line[k]); end
    end
    line_ack = 1'b1;
    tick();
    line_ack = 1'b0;
  endtask

`ifdef LFB_EARLY_WORD_EN
  task automatic test_early();
    int pulses;
    pulses = 0;
    start = 1'b1; start_word = 4'd9;
    tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      beat_valid = 1'b1;
      beat_data  = (i == 0) ? 16'hBEEF : 16'(16'h6000 + i);
      tick();
      if (early_valid === 1'b1) pulses++;
      if (i == 0) begin
        n_checks++; if (early_valid !== 1'b1 || early_data !== 16'hBEEF) begin n_fail++; $display("FAIL early_first got %b/%h want 1/beef", early_valid, early_data); end
      end
    end
    beat_valid = 1'b0;
    tick();
    if (early_valid === 1'b1) pulses++;
    n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL early_pulses got %0d want 1", pulses); end
    n_checks++; if (early_data !== 16'hBEEF) begin n_fail++; $display("FAIL early_hold got %h want beef", early_data); end
    line_ack = 1'b1;
    tick();
    line_ack = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_linear();
    test_wrap();
    test_merge();
    test_stall_hold();
    test_reset_mid();
`ifdef LFB_EARLY_WORD_EN
    test_early();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/line_fill_buffer.md
Name: line_fill_buffer

Overview:
- Assembles one cache line from a word-serial memory burst and exposes the whole line to the cache datapath.
- It is the write-side counterpart of the 16:1 word-select mux: that mux reads one word out of a line; this block writes words into a line by index.
- It supports critical-word-first wrap order and byte-masked store merge of one pending CPU write during the fill.
- It sits between the memory burst interface and the cache data array write port.

Parameters:
width, 16, bits per word
WORDS, 16, words per line (fixed at 16; index is 4 bits)

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  begin a fill; sampled only in IDLE
start_word  input  4  index of the first beat (critical word)
beat_valid  input  1  memory beat present
beat_data  input  width  memory beat word
beat_ready  output  1  buffer accepts a beat this cycle
merge_en  input  1  CPU store to merge into the line
merge_sel  input  4  word index of the store
merge_data  input  width  store data
merge_mask  input  width/8  byte enables; bit i covers bits [8i+7:8i]
merge_ready  output  1  store accepted this cycle
line_out  output  WORDS*width  assembled line; word k is at bits [k*width +: width]
line_valid  output  1  line complete and stable
line_ack  input  1  consumer has taken the line
busy  output  1  state is not IDLE

Behaviour:
- Reset is asynchronous, active-low. It forces:
  - state=IDLE, beat count=0, filled[15:0]=0, pending merge cleared;
  - line_out=0, line_valid=0, beat_ready=0, merge_ready=0, busy=0.
- A reset mid-fill abandons the line; no partial line_valid is ever produced.
- States:
  - IDLE: start=1 latches start_word into base and clears count and filled, then goes to FILL.
  - FILL: beat_ready=1. A beat is accepted when beat_valid&&beat_ready and is written to word (base+count) mod 16, wrapping with 4-bit arithmetic. filled of that word is set and count increments. On the 16th accepted beat, go to HOLD.
  - HOLD: line_valid=1, beat_ready=0. line_ack=1 returns to IDLE on the next edge. line_out holds its value until the next fill overwrites it word by word.
- Latency: line_valid rises on the edge after the 16th accepted beat. With no stalls, start to line_valid is 17 cycles.
- start in FILL or HOLD is ignored. beat_valid outside FILL is ignored.
- Merge (FILL and HOLD only; merge_ready=0 in IDLE):
  - Target word already filled: bytes with mask=1 are written into the buffer the same edge. merge_ready=1.
  - Target not yet filled and no pending merge: the merge is stored in a 1-entry pending register. merge_ready=1.
  - Target not filled and pending occupied: merge_ready=0 and the store is not taken.
  - When a beat lands on the pending word, the stored word is, per byte, mask ? merge : beat. The pending entry is then cleared.
  - Same-cycle beat and merge to the same word: the merge bytes override the beat bytes and the merge is accepted.
  - Merges to the same word in successive cycles apply in order, so the later store wins per byte.
- Mask all-zero is accepted and leaves the word unchanged.

Optional Feature:
- Macro LFB_EARLY_WORD_EN.
- When defined, the block adds two outputs, early_valid(1) and early_data(width).
  - early_valid pulses for exactly one cycle, on the edge after the beat for start_word is accepted, i.e. after the first beat.
  - early_data carries that word, with any merge applied, and holds it until the next fill.
  - Both outputs reset to 0.
- When undefined, the ports and logic are absent; the rest of the behaviour is identical.

Decomposition:
- Package lfb_pkg holds:
  - the state enum (IDLE, FILL, HOLD);
  - the constant LFB_WORDS=16 and the 4-bit word-index typedef;
  - a byte-merge function (old, new, mask) -> word.
- Sub-module lfb_word_merge: a combinational per-byte merge of one word, instantiated once on the write path.
- Storage, counter and FSM stay in the top.

Test Plan:
- start_word=0, 16 back-to-back beats of 0x1000+k → word k=0x1000+k; line_valid on the cycle after the 16th beat; beat_ready drops.
- start_word=13, beats D0..D15 → word (13+i)%16=Di, so word 13=D0 and word 12=D15; wrap is correct.
- Merge sel=5, mask=2'b01, data 0x00AB before beat 5 (beat 5 data 0x1234) → word 5=0x12AB. A second merge to an unfilled word while pending is held gets merge_ready=0.
- beat_valid toggling every other cycle, with line_ack withheld 3 cycles → line_valid held, line_out stable, start ignored while in HOLD; the ack returns the block to IDLE.
- rst_n low after 7 beats → all outputs 0 immediately. A new fill after release completes normally with no stale filled bits.
- LFB_EARLY_WORD_EN, start_word=9, first beat 0xBEEF → early_valid pulses once with 0xBEEF.
